fifomem_mc: RTL and testbench
=============================

Name: fifomem_mc

Overview:
- Single-clock, multi-channel FIFO buffer: NCH logical FIFOs share one storage array; each channel has its own pointers, occupancy count and full/empty flags.
- Next-generation fifomem for the single-clock datapath: adds per-channel full/empty, accept/valid handshakes, occupancy reporting and channel flush.
- Sits between the packet classifier (writer) and the per-channel drain scheduler (reader).

Parameters:
- DATA_W, default DATASIZE (definitions), word width.
- CH_AW, default 2, channel-index width; NCH = 1<<CH_AW.
- DEPTH_AW, default ADDRSIZE (definitions), per-channel address width; DEPTH = 1<<DEPTH_AW.
- CNT_W, default 16, width of the global write/read event counters.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  write request.
- wr_ch  input  CH_AW  target channel of write.
- wr_data  input  DATA_W  write data.
- wr_acc  output  1  combinational: wr_req & ~full[wr_ch] & ~(flush & flush_ch==wr_ch).
- rd_req  input  1  read request.
- rd_ch  input  CH_AW  source channel of read.
- rd_acc  output  1  combinational: rd_req & ~empty[rd_ch] & ~(flush & flush_ch==rd_ch).
- rd_valid  output  1  registered; high the cycle after an accepted read.
- rd_data  output  DATA_W  registered read word; holds its value when rd_valid is low.
- rd_ch_out  output  CH_AW  channel of the rd_data word.
- flush  input  1  empty the channel given by flush_ch.
- flush_ch  input  CH_AW  channel to flush.
- full  output  NCH  per-channel full, registered.
- empty  output  NCH  per-channel empty, registered.
- occ  output  NCH*(DEPTH_AW+1)  packed per-channel occupancy, 0..DEPTH; channel c occupies bits [c*(DEPTH_AW+1) +: DEPTH_AW+1].
- wcnt  output  CNT_W  count of accepted writes; wraps modulo 2^CNT_W.
- rcnt  output  CNT_W  count of accepted reads; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and occ = 0; empty = all ones; full = 0; rd_valid = 0; rd_data = 0; rd_ch_out = 0; wcnt = rcnt = 0. Storage is not cleared.
- Reset asserted mid-operation: an in-flight read is dropped and rd_valid deasserts immediately.
- Storage: DEPTH*NCH words addressed {ch, ptr}. Each channel keeps wptr/rptr of DEPTH_AW+1 bits (wrap bit plus address).
  - full when pointer addresses are equal and wrap bits differ.
  - empty when pointers are equal.
- Accepted write: mem[{wr_ch, wptr[wr_ch]}] <= wr_data; wptr increments, wrapping naturally; wcnt increments.
- Accepted read: rd_data <= mem[{rd_ch, rptr[rd_ch]}]; rd_ch_out <= rd_ch; rd_valid <= 1; rptr increments; rcnt increments. Latency: 1 cycle from acceptance to data.
- Same cycle, different channels: both operations proceed independently.
- Same channel, both accepted: occ unchanged; flags unchanged.
- Same channel while empty: write accepted, read refused (no bypass). The written data becomes readable next cycle.
- Same channel while full: write refused even if a read is accepted that cycle, because flags are registered.
- Flags and occ update on the clock edge after the event and always reflect post-edge state.
- Flush: at the edge, rptr[flush_ch] <= wptr[flush_ch], occ = 0, empty = 1, full = 0.
  - Flush has priority: reads and writes to the flushed channel that cycle are refused.
  - Other channels are unaffected.
  - wcnt/rcnt do not count flushed words.
- Request inputs with req low are don't-care; no side effects.

Optional Feature:
- Macro FIFOMEM_MC_ERR_EN.
- Defined: adds outputs ovf_err (NCH) and udf_err (NCH), plus input err_clr (1).
  - ovf_err[c] is set sticky when wr_req targets full channel c.
  - udf_err[c] is set sticky when rd_req targets empty channel c.
  - err_clr clears both; a set event in the same cycle wins over clear.
  - Both reset to 0.
- Undefined: ports absent; refused requests are silently ignored.

Decomposition:
- Package definitions gains CH_AW_DEF, DEPTH_AW_DEF, CNT_W_DEF and typedef ch_t (logic [CH_AW_DEF-1:0]); DATASIZE/ADDRSIZE are reused.
- Sub-module fifomem_ch_ctrl, instanced NCH times via generate. It owns one channel's wptr, rptr, occ, full and empty, with inputs do_wr, do_rd and do_flush.
- Top level owns the storage array, accept logic, read register and counters.

Test Plan:
- Reset mid-read: accepted read on ch1, rst_n low before the edge -> rd_valid = 0, empty = 4'b1111, occ all 0, wcnt = rcnt = 0.
- Fill ch2 (DEPTH_AW=4): 16 writes 0x00..0x0F -> full = 4'b0100, occ[2] = 16; 17th write gets wr_acc = 0, wcnt = 16. Then 16 reads -> rd_data 0x00..0x0F in order, 1-cycle latency, empty[2] = 1.
- Wrap-around: write/read ch0 40 words with occupancy between 1 and 3 -> data order preserved across pointer wrap; occ[0] never exceeds 3.
- Empty same-channel race: ch3 empty, wr_req and rd_req on ch3 same cycle -> wr_acc = 1, rd_acc = 0; next cycle a read returns the written word.
- Flush: ch1 occ = 5, flush ch1 with a simultaneous write to ch1 and a write to ch0 -> ch1 write refused, occ[1] = 0, empty[1] = 1; ch0 occ increments by 1.
- With FIFOMEM_MC_ERR_EN: read of empty ch0 -> udf_err = 4'b0001; err_clr together with a new write to full ch2 -> ovf_err = 4'b0100, udf_err cleared.

Source files
------------

// File: rtl/fifomem_mc_pkg.sv
// Shared definitions for the multi-channel FIFO: default widths and the channel index type.
package fifomem_mc_pkg;

    localparam int DATASIZE     = 8;
    localparam int ADDRSIZE     = 4;
    localparam int CH_AW_DEF    = 2;
    localparam int DEPTH_AW_DEF = ADDRSIZE;
    localparam int CNT_W_DEF    = 16;

    typedef logic [CH_AW_DEF-1:0] ch_t;

endpackage

// File: rtl/fifomem_ch_ctrl.sv
// Per-channel pointer/flag controller: owns wptr, rptr, occupancy and registered full/empty.
module fifomem_ch_ctrl
    import fifomem_mc_pkg::*;
#(
    parameter int DEPTH_AW = DEPTH_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              do_wr,
    input  logic              do_rd,
    input  logic              do_flush,
    output logic [DEPTH_AW:0] wptr,
    output logic [DEPTH_AW:0] rptr,
    output logic [DEPTH_AW:0] occ,
    output logic              full,
    output logic              empty
);

    logic [DEPTH_AW:0] wptr_q, wptr_d;
    logic [DEPTH_AW:0] rptr_q, rptr_d;
    logic [DEPTH_AW:0] occ_q, occ_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    // Flags are derived from the next pointers so they describe post-edge state.
    always_comb begin
        wptr_d  = wptr_q + {{DEPTH_AW{1'b0}}, do_wr};
        rptr_d  = do_flush ? wptr_q : rptr_q + {{DEPTH_AW{1'b0}}, do_rd};
        occ_d   = wptr_d - rptr_d;
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[DEPTH_AW-1:0] == rptr_d[DEPTH_AW-1:0]) &&
                  (wptr_d[DEPTH_AW] != rptr_d[DEPTH_AW]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign wptr  = wptr_q;
    assign rptr  = rptr_q;
    assign occ   = occ_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/fifomem_mc.sv
// Multi-channel FIFO sharing one storage array; define FIFOMEM_MC_ERR_EN for sticky
// overflow/underflow error flags with err_clr.
module fifomem_mc
    import fifomem_mc_pkg::*;
#(
    parameter int DATA_W   = DATASIZE,
    parameter int CH_AW    = CH_AW_DEF,
    parameter int DEPTH_AW = DEPTH_AW_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_req,
    input  logic [CH_AW-1:0]                    wr_ch,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic                                wr_acc,
    input  logic                                rd_req,
    input  logic [CH_AW-1:0]                    rd_ch,
    output logic                                rd_acc,
    output logic                                rd_valid,
    output logic [DATA_W-1:0]                   rd_data,
    output logic [CH_AW-1:0]                    rd_ch_out,
    input  logic                                flush,
    input  logic [CH_AW-1:0]                    flush_ch,
    output logic [(1<<CH_AW)-1:0]               full,
    output logic [(1<<CH_AW)-1:0]               empty,
    output logic [(1<<CH_AW)*(DEPTH_AW+1)-1:0]  occ,
`ifdef FIFOMEM_MC_ERR_EN
    output logic [(1<<CH_AW)-1:0]               ovf_err,
    output logic [(1<<CH_AW)-1:0]               udf_err,
    input  logic                                err_clr,
`endif
    output logic [CNT_W-1:0]                    wcnt,
    output logic [CNT_W-1:0]                    rcnt
);

    localparam int NCH   = 1 << CH_AW;
    localparam int DEPTH = 1 << DEPTH_AW;
    localparam int PW    = DEPTH_AW + 1;

    logic [DATA_W-1:0] mem [NCH*DEPTH];

    logic [PW-1:0]  wptr [NCH];
    logic [PW-1:0]  rptr [NCH];
    logic [NCH-1:0] do_wr, do_rd, do_flush;
    logic           wr_blk, rd_blk;
    logic [CH_AW+DEPTH_AW-1:0] wr_addr, rd_addr;

    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CH_AW-1:0]  rd_ch_q, rd_ch_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;

    // Flush wins over any access to the same channel in the same cycle.
    always_comb begin
        wr_blk   = flush && (flush_ch == wr_ch);
        rd_blk   = flush && (flush_ch == rd_ch);
        wr_acc   = wr_req && !full[wr_ch] && !wr_blk;
        rd_acc   = rd_req && !empty[rd_ch] && !rd_blk;
        wr_addr  = {wr_ch, wptr[wr_ch][DEPTH_AW-1:0]};
        rd_addr  = {rd_ch, rptr[rd_ch][DEPTH_AW-1:0]};
        do_wr    = '0;
        do_rd    = '0;
        do_flush = '0;
        if (wr_acc) do_wr[wr_ch] = 1'b1;
        if (rd_acc) do_rd[rd_ch] = 1'b1;
        if (flush)  do_flush[flush_ch] = 1'b1;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        fifomem_ch_ctrl #(.DEPTH_AW(DEPTH_AW)) u_ctrl (
            .clk      (clk),
            .rst_n    (rst_n),
            .do_wr    (do_wr[g]),
            .do_rd    (do_rd[g]),
            .do_flush (do_flush[g]),
            .wptr     (wptr[g]),
            .rptr     (rptr[g]),
            .occ      (occ[g*PW +: PW]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    // Storage has no reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        if (rd_acc) begin
            rd_data_d = mem[rd_addr];
            rd_ch_d   = rd_ch;
            rcnt_d    = rcnt_q + 1'b1;
        end
        if (wr_acc) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ch_out = rd_ch_q;
    assign wcnt      = wcnt_q;
    assign rcnt      = rcnt_q;

`ifdef FIFOMEM_MC_ERR_EN
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] udf_q, udf_d;
    logic [NCH-1:0] ovf_set, udf_set;

    // A set event in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_set = '0;
        udf_set = '0;
        if (wr_req && full[wr_ch])  ovf_set[wr_ch] = 1'b1;
        if (rd_req && empty[rd_ch]) udf_set[rd_ch] = 1'b1;
        ovf_d = ovf_set | (ovf_q & {NCH{!err_clr}});
        udf_d = udf_set | (udf_q & {NCH{!err_clr}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_fifomem_mc.sv
// Directed self-checking bench for fifomem_mc (default 8-bit data, 4 channels, depth 16).
module tb_fifomem_mc;

    localparam int DATA_W   = 8;
    localparam int CH_AW    = 2;
    localparam int DEPTH_AW = 4;
    localparam int CNT_W    = 16;
    localparam int NCH      = 1 << CH_AW;
    localparam int PW       = DEPTH_AW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wr_req, rd_req, flush;
    logic [CH_AW-1:0]     wr_ch, rd_ch, flush_ch;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_acc, rd_acc, rd_valid;
    logic [DATA_W-1:0]    rd_data;
    logic [CH_AW-1:0]     rd_ch_out;
    logic [NCH-1:0]       full, empty;
    logic [NCH*PW-1:0]    occ;
    logic [CNT_W-1:0]     wcnt, rcnt;
`ifdef FIFOMEM_MC_ERR_EN
    logic [NCH-1:0]       ovf_err, udf_err;
    logic                 err_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rd_idx;

    always #5 clk = ~clk;

    fifomem_mc #(
        .DATA_W(DATA_W), .CH_AW(CH_AW), .DEPTH_AW(DEPTH_AW), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .wr_acc    (wr_acc),
        .rd_req    (rd_req),
        .rd_ch     (rd_ch),
        .rd_acc    (rd_acc),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ch_out (rd_ch_out),
        .flush     (flush),
        .flush_ch  (flush_ch),
        .full      (full),
        .empty     (empty),
        .occ       (occ),
`ifdef FIFOMEM_MC_ERR_EN
        .ovf_err   (ovf_err),
        .udf_err   (udf_err),
        .err_clr   (err_clr),
`endif
        .wcnt      (wcnt),
        .rcnt      (rcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] occ_of(input int c);
        return occ[c*PW +: PW];
    endfunction

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
        wr_ch = '0; rd_ch = '0; flush_ch = '0; wr_data = '0;
`ifdef FIFOMEM_MC_ERR_EN
        err_clr = 1'b0;
`endif
        tick(); tick();
        check("rst_empty", empty, 4'b1111);
        check("rst_full", full, 4'b0000);
        check("rst_occ", occ, '0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wcnt", wcnt, 0);
        rst_n = 1'b1;

        // Reset mid-read on ch1
        wr_req = 1'b1; wr_ch = 2'd1; wr_data = 8'hA5; tick();
        wr_data = 8'hA6; tick();
        wr_req = 1'b0;
        check("mid_occ1", occ_of(1), 2);
        rd_req = 1'b1; rd_ch = 2'd1; #1;
        check("mid_rd_acc", rd_acc, 1);
        tick();
        check("mid_rd_valid", rd_valid, 1);
        check("mid_rd_data", rd_data, 8'hA5);
        #2 rst_n = 1'b0; #1;
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_empty", empty, 4'b1111);
        check("mid_rst_occ", occ, '0);
        check("mid_rst_wcnt", wcnt, 0);
        check("mid_rst_rcnt", rcnt, 0);
        rd_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Fill ch2 to full, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_ch = 2'd2; wr_data = 8'(i); #1;
            check("fill_wr_acc", wr_acc, 1);
            tick();
        end
        check("fill_full", full, 4'b0100);
        check("fill_occ2", occ_of(2), 16);
        check("fill_empty", empty, 4'b1011);
        wr_data = 8'hEE; #1;
        check("fill_17th_acc", wr_acc, 0);
        tick();
        wr_req = 1'b0;
        check("fill_wcnt", wcnt, 16);
        check("fill_occ2_hold", occ_of(2), 16);

        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1; rd_ch = 2'd2; #1;
            check("drain_rd_acc", rd_acc, 1);
            tick();
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, 8'(i));
            check("drain_ch", rd_ch_out, 2);
        end
        check("drain_empty", empty, 4'b1111);
        check("drain_full", full, 4'b0000);
        #1;
        check("drain_refused", rd_acc, 0);
        rd_req = 1'b0;
        tick();
        check("drain_valid_low", rd_valid, 0);
        check("drain_data_hold", rd_data, 8'h0F);
        check("drain_rcnt", rcnt, 16);

        // Wrap-around on ch0 with occupancy held at 2
        rd_idx = 0;
        wr_req = 1'b1; wr_ch = 2'd0; wr_data = 8'h40; tick();
        wr_data = 8'h41; tick();
        check("wrap_occ_start", occ_of(0), 2);
        for (int k = 2; k < 40; k++) begin
            wr_data = 8'(8'h40 + k); rd_req = 1'b1; rd_ch = 2'd0; #1;
            check("wrap_acc", {wr_acc, rd_acc}, 2'b11);
            tick();
            check("wrap_data", rd_data, 8'(8'h40 + rd_idx));
            rd_idx++;
            check("wrap_occ_le3", occ_of(0) <= 3, 1);
        end
        wr_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("wrap_tail_data", rd_data, 8'(8'h40 + rd_idx));
            rd_idx++;
        end
        rd_req = 1'b0;
        check("wrap_empty", empty[0], 1);
        check("wrap_wcnt", wcnt, 56);
        check("wrap_rcnt", rcnt, 56);

        // Empty same-channel race on ch3
        wr_req = 1'b1; wr_ch = 2'd3; wr_data = 8'h3C;
        rd_req = 1'b1; rd_ch = 2'd3; #1;
        check("race_wr_acc", wr_acc, 1);
        check("race_rd_acc", rd_acc, 0);
        tick();
        wr_req = 1'b0;
        check("race_no_valid", rd_valid, 0);
        check("race_occ3", occ_of(3), 1);
        #1;
        check("race_rd_acc2", rd_acc, 1);
        tick();
        rd_req = 1'b0;
        check("race_valid", rd_valid, 1);
        check("race_data", rd_data, 8'h3C);
        check("race_ch", rd_ch_out, 3);

        // Flush ch1 holding 5 words while ch0 takes a write
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_ch = 2'd1; wr_data = 8'(8'h10 + i); tick();
        end
        check("flush_pre_occ1", occ_of(1), 5);
        flush = 1'b1; flush_ch = 2'd1;
        wr_ch = 2'd1; wr_data = 8'h55; rd_req = 1'b1; rd_ch = 2'd1; #1;
        check("flush_wr_block", wr_acc, 0);
        check("flush_rd_block", rd_acc, 0);
        wr_ch = 2'd0; wr_data = 8'h99; rd_req = 1'b0; #1;
        check("flush_other_wr", wr_acc, 1);
        tick();
        flush = 1'b0; wr_req = 1'b0;
        check("flush_occ1", occ_of(1), 0);
        check("flush_empty", empty, 4'b1110);
        check("flush_occ0", occ_of(0), 1);
        check("flush_wcnt", wcnt, 63);
        check("flush_rcnt", rcnt, 57);
        wr_req = 1'b1; wr_ch = 2'd1; wr_data = 8'h77; tick();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_ch = 2'd1; tick();
        check("flush_after_data", rd_data, 8'h77);
        rd_ch = 2'd0; tick();
        rd_req = 1'b0;
        check("flush_ch0_data", rd_data, 8'h99);
        check("flush_final_empty", empty, 4'b1111);
        check("flush_final_cnt", {wcnt, rcnt}, {16'd64, 16'd59});

`ifdef FIFOMEM_MC_ERR_EN
        check("err_init", {ovf_err, udf_err}, 8'h00);
        rd_req = 1'b1; rd_ch = 2'd0; tick();
        rd_req = 1'b0;
        check("err_udf", udf_err, 4'b0001);
        check("err_ovf0", ovf_err, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_ch = 2'd2; wr_data = 8'(i); tick();
        end
        check("err_full2", full, 4'b0100);
        err_clr = 1'b1; wr_data = 8'hAA; #1;
        check("err_ovf_refused", wr_acc, 0);
        tick();
        err_clr = 1'b0; wr_req = 1'b0;
        check("err_ovf", ovf_err, 4'b0100);
        check("err_udf_clr", udf_err, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
